nibble_cpu_core: RTL and testbench



---
 rtl/nibble_cpu_core.sv | 200 ++++++++++++++++++++
 tb/tb_nibble_cpu_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_cpu_core.sv
// Parametrised A/X/Y accumulator CPU with a req/ack memory bus.
// Each instruction is three program nibbles: opcode, {mode, rsel}, imm.
module nibble_cpu_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_space,
    output logic [ADDR_W+1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc
);
    typedef enum logic [2:0] {FETCH, EXEC, LOAD, STORE, ALU, HALT} state_t;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_CMP  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BCS  = 4'hA;
    localparam logic [3:0] OP_BCC  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state;
    logic [1:0]        beat;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] reg_a, reg_x, reg_y, operand;
    logic              flag_z, flag_c;
    logic [3:0]        opcode, imm;
    logic [1:0]        mode, rsel;

    logic [DATA_W-1:0] cur_r, result;
    logic [DATA_W:0]   sum_ext;
    logic [3:0]        data_addr;
    logic              mem_mode, needs_load;
    logic              write_r, set_flags, set_c, new_c, taken;
    logic [ADDR_W-1:0] next_pc;

    always_comb begin
        case (rsel)
            2'd1:    cur_r = reg_x;
            2'd2:    cur_r = reg_y;
            default: cur_r = reg_a;
        endcase
    end

    assign mem_mode   = (mode == 2'd1) || (mode == 2'd2);
    assign data_addr  = (mode == 2'd2) ? imm + reg_x[3:0] : imm;
    assign needs_load = mem_mode && (opcode <= OP_CMP) && (opcode != OP_ST);
    assign sum_ext    = {1'b0, cur_r} + {1'b0, operand};
    assign dbg_pc     = pc;

    always_comb begin
        result    = cur_r;
        write_r   = 1'b0;
        set_flags = 1'b0;
        set_c     = 1'b0;
        new_c     = flag_c;
        taken     = 1'b0;
        case (opcode)
            OP_LD:  begin result = operand; write_r = 1'b1; set_flags = 1'b1; end
            OP_ADD: begin
                result = sum_ext[DATA_W-1:0]; write_r = 1'b1; set_flags = 1'b1;
                set_c = 1'b1; new_c = sum_ext[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                result = cur_r - operand; write_r = (opcode == OP_SUB); set_flags = 1'b1;
                set_c = 1'b1; new_c = (cur_r >= operand);
            end
            OP_AND: begin result = cur_r & operand; write_r = 1'b1; set_flags = 1'b1; end
            OP_OR:  begin result = cur_r | operand; write_r = 1'b1; set_flags = 1'b1; end
            OP_XOR: begin result = cur_r ^ operand; write_r = 1'b1; set_flags = 1'b1; end
            OP_BNE: taken = !flag_z;
            OP_BEQ: taken = flag_z;
            OP_BCS: taken = flag_c;
            OP_BCC: taken = !flag_c;
            default: ;
        endcase
        // pc has already been incremented past the branch when this offset is applied
        next_pc = taken ? pc + {{(ADDR_W-4){imm[3]}}, imm} : pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            beat      <= 2'd0;
            pc        <= '0;
            reg_a     <= '0;
            reg_x     <= '0;
            reg_y     <= '0;
            operand   <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            opcode    <= 4'h0;
            mode      <= 2'd0;
            rsel      <= 2'd0;
            imm       <= 4'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_space <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_space <= 1'b0;
                        mem_addr  <= {pc, beat};
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        case (beat)
                            2'd0: begin opcode <= mem_rdata[3:0]; beat <= 2'd1; end
                            2'd1: begin {mode, rsel} <= mem_rdata[3:0]; beat <= 2'd2; end
                            default: begin
                                imm   <= mem_rdata[3:0];
                                beat  <= 2'd0;
                                pc    <= pc + ADDR_W'(1);
                                state <= EXEC;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    operand <= DATA_W'(imm);
                    if (opcode == OP_ST)
                        state <= mem_mode ? STORE : ALU;
                    else if (needs_load)
                        state <= LOAD;
                    else
                        state <= ALU;
                end
                LOAD: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_space <= 1'b1;
                        mem_addr  <= {{(ADDR_W-2){1'b0}}, data_addr};
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        operand <= mem_rdata;
                        state   <= ALU;
                    end
                end
                STORE: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_space <= 1'b1;
                        mem_addr  <= {{(ADDR_W-2){1'b0}}, data_addr};
                        mem_wdata <= cur_r;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= FETCH;
                    end
                end
                ALU: begin
                    if (write_r) begin
                        case (rsel)
                            2'd1:    reg_x <= result;
                            2'd2:    reg_y <= result;
                            default: reg_a <= result;
                        endcase
                    end
                    if (set_flags) flag_z <= (result == '0);
                    if (set_c) flag_c <= new_c;
                    if (opcode == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        // Issue the next beat-0 fetch here to save a cycle per instruction
                        pc        <= next_pc;
                        beat      <= 2'd0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_space <= 1'b0;
                        mem_addr  <= {next_pc, 2'b00};
                        state     <= FETCH;
                    end
                end
                HALT: ;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_cpu_core.sv
// Directed bench for nibble_cpu_core: an 8-bit core with a bus responder
// and a 4-bit core for the narrow-width regression.
module tb_nibble_cpu_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        rst8 = 1'b1;
    logic        req8, we8, space8, ack8, halted8;
    logic [11:0] addr8;
    logic [7:0]  wdata8, rdata8;
    logic [9:0]  pc8;

    logic        rst4 = 1'b1;
    logic        req4, we4, space4, ack4, halted4;
    logic [11:0] addr4;
    logic [3:0]  wdata4, rdata4;
    logic [9:0]  pc4;

    nibble_cpu_core #(.DATA_W(8), .ADDR_W(10)) dut8 (
        .clk(clk), .rst(rst8), .mem_req(req8), .mem_we(we8), .mem_space(space8),
        .mem_addr(addr8), .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ack(ack8),
        .halted(halted8), .dbg_pc(pc8)
    );

    nibble_cpu_core #(.DATA_W(4), .ADDR_W(10)) dut4 (
        .clk(clk), .rst(rst4), .mem_req(req4), .mem_we(we4), .mem_space(space4),
        .mem_addr(addr4), .mem_wdata(wdata4), .mem_rdata(rdata4), .mem_ack(ack4),
        .halted(halted4), .dbg_pc(pc4)
    );

    logic [7:0] prog [0:4095];
    logic [7:0] dmem [0:15];

    logic manual8 = 1'b0;
    logic manual_ack8 = 1'b0;
    logic rand_delay = 1'b0;

    int fetch_cnt, write_cnt, read_cnt, stable_viol, wait_cnt, pc0_fetches, max_fetch_pc;
    logic        armed;
    logic [11:0] hold_addr, last_read_addr, last_wr_addr;
    logic [7:0]  hold_wdata, last_wdata;
    logic        hold_we, hold_space, last_wr_space;

    // Responder for the 8-bit core: optional random wait states, bus-stability watch
    always @(negedge clk) begin
        if (rst8) begin
            ack8 = 1'b0; armed = 1'b0; rdata8 = 8'h00;
            fetch_cnt = 0; write_cnt = 0; read_cnt = 0; stable_viol = 0;
            pc0_fetches = 0; max_fetch_pc = 0; wait_cnt = 0;
            last_read_addr = '0; last_wr_addr = '0; last_wdata = '0; last_wr_space = 1'b0;
        end else if (manual8) begin
            ack8 = manual_ack8; armed = 1'b0;
        end else if (ack8) begin
            ack8 = 1'b0;
        end else if (req8) begin
            if (!armed) begin
                armed = 1'b1;
                wait_cnt = rand_delay ? int'($urandom_range(5, 0)) : 0;
                hold_addr = addr8; hold_wdata = wdata8; hold_we = we8; hold_space = space8;
            end else if (addr8 !== hold_addr || wdata8 !== hold_wdata ||
                         we8 !== hold_we || space8 !== hold_space) begin
                stable_viol++;
            end
            if (wait_cnt == 0) begin
                armed = 1'b0;
                ack8 = 1'b1;
                if (we8) begin
                    write_cnt++; last_wr_addr = addr8; last_wdata = wdata8; last_wr_space = space8;
                end else if (space8) begin
                    read_cnt++; last_read_addr = addr8; rdata8 = dmem[addr8[3:0]];
                end else begin
                    fetch_cnt++; rdata8 = prog[addr8];
                    if (addr8 == 12'd0) pc0_fetches++;
                    if (addr8[1:0] == 2'b00 && int'(addr8[11:2]) > max_fetch_pc)
                        max_fetch_pc = int'(addr8[11:2]);
                end
            end else begin
                wait_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst4 || ack4) begin
            ack4 = 1'b0;
        end else if (req4) begin
            ack4 = 1'b1;
            rdata4 = space4 ? 4'h0 : prog[addr4][3:0];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst8 = 1'b1;
        step(2);
        rst8 = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) prog[i] = 8'hFF;
        for (int i = 0; i < 16; i++) dmem[i] = 8'h00;
    endtask

    // Upper nibbles hold junk so any use of rdata[7:4] during fetch shows up
    task automatic put(input int idx, input logic [3:0] op, input logic [1:0] md,
                       input logic [1:0] rs, input logic [3:0] im);
        prog[idx*4]     = {4'hA, op};
        prog[idx*4 + 1] = {4'h5, md, rs};
        prog[idx*4 + 2] = {4'h3, im};
    endtask

    task automatic run8(input int budget, output int cyc);
        cyc = 0;
        while (halted8 !== 1'b1 && cyc < budget) begin
            @(posedge clk); #2;
            cyc++;
        end
    endtask

    task automatic test_reset();
        step(2);
        vectors++; if (req8 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %b, expected 0", req8); end
        vectors++; if (we8 !== 1'b0 || space8 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we_space: got %b%b, expected 00", we8, space8); end
        vectors++; if (wdata8 !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_wdata: got %h, expected 00", wdata8); end
        vectors++; if (halted8 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_halted: got %b, expected 0", halted8); end
        vectors++; if (pc8 !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_pc: got %h, expected 000", pc8); end
        vectors++; if (dut8.reg_a !== 8'h00 || dut8.flag_z !== 1'b0 || dut8.flag_c !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_regs: got A=%h Z=%b C=%b, expected 00/0/0", dut8.reg_a, dut8.flag_z, dut8.flag_c); end
    endtask

    task automatic test_immediate();
        int cyc;
        clear_mem();
        put(0, 4'h0, 2'd0, 2'd0, 4'h5);
        put(1, 4'h2, 2'd0, 2'd0, 4'hC);
        put(2, 4'hF, 2'd0, 2'd0, 4'h0);
        do_reset();
        run8(200, cyc);
        vectors++; if (cyc !== 22) begin miscompares++; $display("[TB] FAIL imm_cycles: got %0d, expected 22", cyc); end
        vectors++; if (dut8.reg_a !== 8'h11) begin miscompares++; $display("[TB] FAIL imm_a: got %h, expected 11", dut8.reg_a); end
        vectors++; if (dut8.flag_c !== 1'b0 || dut8.flag_z !== 1'b0) begin miscompares++; $display("[TB] FAIL imm_flags: got C=%b Z=%b, expected 0/0", dut8.flag_c, dut8.flag_z); end
        vectors++; if (pc8 !== 10'd3) begin miscompares++; $display("[TB] FAIL imm_pc: got %0d, expected 3", pc8); end
        step(5);
        vectors++; if (fetch_cnt !== 9) begin miscompares++; $display("[TB] FAIL imm_fetches: got %0d, expected 9", fetch_cnt); end
        vectors++; if (req8 !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_req: got %b, expected 0", req8); end
    endtask

    task automatic test_indexed_load();
        int cyc;
        clear_mem();
        dmem[7] = 8'hFF;
        put(0, 4'h0, 2'd0, 2'd1, 4'h2);
        put(1, 4'h0, 2'd2, 2'd0, 4'h5);
        put(2, 4'h2, 2'd0, 2'd0, 4'h1);
        put(3, 4'hF, 2'd0, 2'd0, 4'h0);
        do_reset();
        run8(300, cyc);
        vectors++; if (cyc !== 31) begin miscompares++; $display("[TB] FAIL idx_cycles: got %0d, expected 31", cyc); end
        vectors++; if (read_cnt !== 1 || last_read_addr !== 12'd7) begin miscompares++; $display("[TB] FAIL idx_read: got %0d reads at %h, expected 1 at 007", read_cnt, last_read_addr); end
        vectors++; if (dut8.reg_a !== 8'h00) begin miscompares++; $display("[TB] FAIL idx_a: got %h, expected 00", dut8.reg_a); end
        vectors++; if (dut8.flag_z !== 1'b1 || dut8.flag_c !== 1'b1) begin miscompares++; $display("[TB] FAIL idx_flags: got Z=%b C=%b, expected 1/1", dut8.flag_z, dut8.flag_c); end
        vectors++; if (dut8.reg_x !== 8'h02) begin miscompares++; $display("[TB] FAIL idx_x: got %h, expected 02", dut8.reg_x); end
    endtask

    task automatic test_store();
        int cyc;
        clear_mem();
        dmem[4] = 8'h5A;
        put(0, 4'h0, 2'd1, 2'd2, 4'h4);
        put(1, 4'h1, 2'd1, 2'd2, 4'h3);
        put(2, 4'hF, 2'd0, 2'd0, 4'h0);
        rand_delay = 1'b1;
        do_reset();
        run8(500, cyc);
        rand_delay = 1'b0;
        vectors++; if (halted8 !== 1'b1) begin miscompares++; $display("[TB] FAIL st_halted: got %b, expected 1", halted8); end
        vectors++; if (write_cnt !== 1) begin miscompares++; $display("[TB] FAIL st_count: got %0d, expected 1", write_cnt); end
        vectors++; if (last_wr_space !== 1'b1 || last_wr_addr !== 12'd3) begin miscompares++; $display("[TB] FAIL st_addr: got space=%b addr=%h, expected 1/003", last_wr_space, last_wr_addr); end
        vectors++; if (last_wdata !== 8'h5A) begin miscompares++; $display("[TB] FAIL st_wdata: got %h, expected 5a", last_wdata); end
        vectors++; if (stable_viol !== 0) begin miscompares++; $display("[TB] FAIL bus_stable: got %0d changes, expected 0", stable_viol); end
        vectors++; if (dut8.reg_y !== 8'h5A) begin miscompares++; $display("[TB] FAIL st_y: got %h, expected 5a", dut8.reg_y); end
    endtask

    task automatic test_logic();
        int cyc;
        clear_mem();
        put(0, 4'h0, 2'd0, 2'd1, 4'hC);
        put(1, 4'h4, 2'd0, 2'd1, 4'hA);
        put(2, 4'h6, 2'd0, 2'd1, 4'hD);
        put(3, 4'h0, 2'd0, 2'd2, 4'hC);
        put(4, 4'h5, 2'd0, 2'd2, 4'h3);
        put(5, 4'h0, 2'd0, 2'd3, 4'h9);
        put(6, 4'h3, 2'd0, 2'd3, 4'h4);
        put(7, 4'h7, 2'd0, 2'd0, 4'h5);
        put(8, 4'hF, 2'd0, 2'd0, 4'h0);
        do_reset();
        run8(300, cyc);
        vectors++; if (cyc !== 64) begin miscompares++; $display("[TB] FAIL logic_cycles: got %0d, expected 64", cyc); end
        vectors++; if (dut8.reg_x !== 8'h05) begin miscompares++; $display("[TB] FAIL and_xor_x: got %h, expected 05", dut8.reg_x); end
        vectors++; if (dut8.reg_y !== 8'h0F) begin miscompares++; $display("[TB] FAIL or_y: got %h, expected 0f", dut8.reg_y); end
        vectors++; if (dut8.reg_a !== 8'h05) begin miscompares++; $display("[TB] FAIL sub_cmp_a: got %h, expected 05", dut8.reg_a); end
        vectors++; if (dut8.flag_z !== 1'b1 || dut8.flag_c !== 1'b1) begin miscompares++; $display("[TB] FAIL cmp_flags: got Z=%b C=%b, expected 1/1", dut8.flag_z, dut8.flag_c); end
    endtask

    task automatic test_branch_loop();
        clear_mem();
        put(0, 4'h7, 2'd0, 2'd0, 4'h0);
        put(1, 4'h9, 2'd0, 2'd0, 4'hE);
        do_reset();
        step(56);
        vectors++; if (halted8 !== 1'b0) begin miscompares++; $display("[TB] FAIL loop_halted: got %b, expected 0", halted8); end
        vectors++; if (pc0_fetches !== 4) begin miscompares++; $display("[TB] FAIL loop_count: got %0d, expected 4", pc0_fetches); end
        vectors++; if (max_fetch_pc !== 1) begin miscompares++; $display("[TB] FAIL loop_max_pc: got %0d, expected 1", max_fetch_pc); end
        vectors++; if (dut8.flag_z !== 1'b1) begin miscompares++; $display("[TB] FAIL loop_z: got %b, expected 1", dut8.flag_z); end
    endtask

    task automatic test_pc_wrap();
        int cyc;
        clear_mem();
        put(0, 4'h8, 2'd0, 2'd0, 4'hE);
        put(1023, 4'hF, 2'd0, 2'd0, 4'h0);
        do_reset();
        run8(100, cyc);
        vectors++; if (cyc !== 15) begin miscompares++; $display("[TB] FAIL wrap_cycles: got %0d, expected 15", cyc); end
        vectors++; if (max_fetch_pc !== 1023) begin miscompares++; $display("[TB] FAIL wrap_branch: got %0d, expected 1023", max_fetch_pc); end
        vectors++; if (pc8 !== 10'd0) begin miscompares++; $display("[TB] FAIL wrap_pc: got %0d, expected 0", pc8); end
    endtask

    task automatic test_reset_mid_fetch();
        int cyc;
        clear_mem();
        put(0, 4'h0, 2'd0, 2'd0, 4'h5);
        put(1, 4'hF, 2'd0, 2'd0, 4'h0);
        do_reset();
        step(8);
        vectors++; if (req8 !== 1'b1 || addr8 !== 12'd4) begin miscompares++; $display("[TB] FAIL mid_fetch: got req=%b addr=%h, expected 1/004", req8, addr8); end
        vectors++; if (dut8.reg_a !== 8'h05) begin miscompares++; $display("[TB] FAIL mid_a: got %h, expected 05", dut8.reg_a); end
        manual8 = 1'b1;
        rst8 = 1'b1;
        step(1);
        vectors++; if (req8 !== 1'b0 || dut8.reg_a !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_drop: got req=%b A=%h, expected 0/00", req8, dut8.reg_a); end
        rst8 = 1'b0;
        manual_ack8 = 1'b1;
        step(1);
        manual_ack8 = 1'b0;
        vectors++; if (req8 !== 1'b1 || addr8 !== 12'd0 || pc8 !== 10'd0) begin miscompares++; $display("[TB] FAIL rst_restart: got req=%b addr=%h pc=%h, expected 1/000/000", req8, addr8, pc8); end
        step(1);
        vectors++; if (req8 !== 1'b1 || addr8 !== 12'd0) begin miscompares++; $display("[TB] FAIL stray_ack: got req=%b addr=%h, expected 1/000", req8, addr8); end
        manual8 = 1'b0;
        run8(100, cyc);
        vectors++; if (halted8 !== 1'b1 || dut8.reg_a !== 8'h05 || pc8 !== 10'd2) begin miscompares++; $display("[TB] FAIL rst_rerun: got halted=%b A=%h pc=%0d, expected 1/05/2", halted8, dut8.reg_a, pc8); end
        vectors++; if (fetch_cnt !== 6) begin miscompares++; $display("[TB] FAIL rst_fetches: got %0d, expected 6", fetch_cnt); end
    endtask

    task automatic test_width4();
        int cyc = 0;
        clear_mem();
        put(0, 4'h3, 2'd0, 2'd0, 4'h1);
        put(1, 4'hF, 2'd0, 2'd0, 4'h0);
        rst4 = 1'b1;
        step(2);
        rst4 = 1'b0;
        while (halted4 !== 1'b1 && cyc < 100) begin
            @(posedge clk); #2;
            cyc++;
        end
        vectors++; if (cyc !== 15) begin miscompares++; $display("[TB] FAIL w4_cycles: got %0d, expected 15", cyc); end
        vectors++; if (dut4.reg_a !== 4'hF) begin miscompares++; $display("[TB] FAIL w4_a: got %h, expected f", dut4.reg_a); end
        vectors++; if (dut4.flag_c !== 1'b0 || dut4.flag_z !== 1'b0) begin miscompares++; $display("[TB] FAIL w4_flags: got C=%b Z=%b, expected 0/0", dut4.flag_c, dut4.flag_z); end
    endtask

    initial begin
        clear_mem();
        @(posedge clk); #2;
        test_reset();
        test_immediate();
        test_indexed_load();
        test_store();
        test_logic();
        test_branch_loop();
        test_pc_wrap();
        test_reset_mid_fetch();
        test_width4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
